if_id_pipe: RTL and testbench

IF_ID_PIPE -- requirements
Module: if_id_pipe

---
 rtl/if_id_pipe.sv | 148 ++++++++++++++
 tb/tb_if_id_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe.sv
// if_id_pipe: two-entry in-order skid buffer between the fetch and decode stages.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high on the same side. if_ready depends only on rst and the registered
// state, never on id_ready. This breaks the combinational ready path from
// decode back to fetch. The skid register absorbs the one entry that arrives
// while decode stalls.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   if_valid/ready  fetch-side handshake
//   if_pc/inst/exc  offered entry
//   flush           drops all held entries and the current offer
//   id_valid/ready  decode-side handshake
//   id_pc/inst/exc  output entry (the main register)
//   stall_cnt       saturating count of cycles with id_valid && !id_ready
module if_id_pipe #(
  parameter int unsigned         PC_W     = 32,
  parameter int unsigned         INST_W   = 32,
  parameter logic [INST_W-1:0]   NOP_INST = '0,
  parameter int unsigned         CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              if_exc,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_exc,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PC_W-1:0]   skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              skid_exc;

  logic in_xfer, out_xfer;
  logic load_main_in, load_main_skid, load_skid, clear_main;

  assign id_valid = (state_q != EMPTY);
  assign if_ready = rst && (state_q != TWO);
  assign in_xfer  = if_valid && if_ready;
  assign out_xfer = id_valid && id_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Next state and register load controls
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_main     = 1'b0;
    if (flush) begin
      // Drops the held entries and the offer, even though if_ready may be high.
      state_d    = EMPTY;
      clear_main = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_d   = TWO;
          end else if (out_xfer) begin
            clear_main = 1'b1;
            state_d    = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Main register. Clearing leaves id_pc alone so the last PC stays visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_pc   <= '0;
      id_inst <= NOP_INST;
      id_exc  <= 1'b0;
    end else if (clear_main) begin
      id_inst <= NOP_INST;
      id_exc  <= 1'b0;
    end else if (load_main_in) begin
      id_pc   <= if_pc;
      id_inst <= if_inst;
      id_exc  <= if_exc;
    end else if (load_main_skid) begin
      id_pc   <= skid_pc;
      id_inst <= skid_inst;
      id_exc  <= skid_exc;
    end
  end

  // Skid register
  always_ff @(posedge clk) begin
    if (!rst) begin
      skid_pc   <= '0;
      skid_inst <= '0;
      skid_exc  <= 1'b0;
    end else if (load_skid) begin
      skid_pc   <= if_pc;
      skid_inst <= if_inst;
      skid_exc  <= if_exc;
    end
  end

  // Stall counter saturates at all-ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (id_valid && !id_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
module tb_if_id_pipe;

  localparam int          PC_W  = 32;
  localparam int          INST_W = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, if_valid, if_exc, flush, id_ready;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready, id_valid, id_exc;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic [15:0]       stall_cnt;

  logic              s_if_ready, s_id_valid, s_id_exc;
  logic [PC_W-1:0]   s_id_pc;
  logic [INST_W-1:0] s_id_inst;
  logic [1:0]        s_stall_cnt;

  if_id_pipe #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_exc(if_exc), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_inst(id_inst), .id_exc(id_exc), .stall_cnt(stall_cnt)
  );

  // Same stimulus, 2-bit stall counter for the saturation check
  if_id_pipe #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(s_if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_exc(if_exc), .flush(flush),
    .id_valid(s_id_valid), .id_ready(id_ready), .id_pc(s_id_pc),
    .id_inst(s_id_inst), .id_exc(s_id_exc), .stall_cnt(s_stall_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              exc;
  } ent_t;

  ent_t            exp_q[$];   // entries held, oldest first
  logic [PC_W-1:0] m_last_pc;
  int unsigned     m_cnt, m_cnt_s;
  int              n_cmp = 0;
  int              n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last_pc = '0;
    m_cnt     = 0;
    m_cnt_s   = 0;
  endtask

  task automatic model_check();
    chk("id_valid",  64'(id_valid), 64'(exp_q.size() > 0));
    chk("if_ready",  64'(if_ready), 64'(rst && exp_q.size() < 2));
    chk("id_pc",     64'(id_pc),    64'(m_last_pc));
    chk("id_inst",   64'(id_inst),  64'(exp_q.size() > 0 ? exp_q[0].inst : NOP));
    chk("id_exc",    64'(id_exc),   64'(exp_q.size() > 0 ? exp_q[0].exc : 1'b0));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    chk("stall_cnt_sat", 64'(s_stall_cnt), 64'(m_cnt_s));
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    bit   acc, pop;
    ent_t e;
    acc = if_valid && rst && (exp_q.size() < 2);
    pop = (exp_q.size() > 0) && id_ready;
    if (!rst) begin
      model_reset();
    end else begin
      if (exp_q.size() > 0 && !id_ready && !flush) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 3) m_cnt_s++;
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
          e.pc = if_pc; e.inst = if_inst; e.exc = if_exc;
          exp_q.push_back(e);
        end
      end
      if (exp_q.size() > 0) m_last_pc = exp_q[0].pc;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at the negedge: check, update model, let the edge happen.
  task automatic tick();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    tick();
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                       input logic e, input logic f, input logic rdy);
    rst = r; if_valid = v; if_pc = pc; if_inst = 32'h1000_0000 | pc;
    if_exc = e; flush = f; id_ready = rdy;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r, v;
    logic [31:0] pc;
    logic        e, f, rdy;
    logic        x_idv, x_ifr;
    logic [31:0] x_pc, x_inst;
    logic        x_exc;
    logic [15:0] x_cnt;
  } vec_t;

  vec_t vt[14];

  initial begin
    // inputs: rst, valid, pc, exc, flush, id_ready | expected outputs this cycle
    vt[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, NOP,          1'b0, 16'd0};
    vt[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00, NOP,          1'b0, 16'd0};
    vt[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 32'h1000_0000, 1'b0, 16'd0};
    vt[3]  = '{1'b1, 1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 32'h1000_0004, 1'b0, 16'd0};
    vt[4]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 32'h1000_0008, 1'b0, 16'd0};
    vt[5]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h08, NOP,          1'b0, 16'd0};
    vt[6]  = '{1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h08, NOP,          1'b0, 16'd0};
    vt[7]  = '{1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h1000_0010, 1'b0, 16'd0};
    vt[8]  = '{1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1000_0010, 1'b0, 16'd1};
    vt[9]  = '{1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1000_0010, 1'b0, 16'd2};
    vt[10] = '{1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h1000_0010, 1'b0, 16'd3};
    vt[11] = '{1'b1, 1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 32'h1000_0014, 1'b1, 16'd3};
    vt[12] = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h18, 32'h1000_0018, 1'b0, 16'd3};
    vt[13] = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h18, NOP,          1'b0, 16'd3};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [1:0] sat_exp[6];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3; sat_exp[5] = 2'd3;

    // Bring both instances out of X before any checking starts
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Streaming and back-pressure, table driven
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].r, vt[i].v, vt[i].pc, vt[i].e, vt[i].f, vt[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d.id_valid", i),  64'(id_valid),  64'(vt[i].x_idv));
      chk($sformatf("tbl%0d.if_ready", i),  64'(if_ready),  64'(vt[i].x_ifr));
      chk($sformatf("tbl%0d.id_pc", i),     64'(id_pc),     64'(vt[i].x_pc));
      chk($sformatf("tbl%0d.id_inst", i),   64'(id_inst),   64'(vt[i].x_inst));
      chk($sformatf("tbl%0d.id_exc", i),    64'(id_exc),    64'(vt[i].x_exc));
      chk($sformatf("tbl%0d.stall_cnt", i), 64'(stall_cnt), 64'(vt[i].x_cnt));
      tick();
    end

    // Flush in TWO with an offer pending: none of the three entries may appear
    do_reset();
    drive(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 32'h24, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 32'h28, 1'b0, 1'b1, 1'b0); cycle();
    chk("flush.id_valid", 64'(id_valid), 64'(0));
    chk("flush.id_inst",  64'(id_inst),  64'(NOP));
    chk("flush.id_exc",   64'(id_exc),   64'(0));
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1); cycle();
      chk("flush.drain_valid", 64'(id_valid), 64'(0));
    end

    // Reset while TWO, then latency-1 restart
    drive(1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 32'h34, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b1, 32'h38, 1'b0, 1'b1, 1'b1); cycle();
    chk("rst2.id_valid",  64'(id_valid),  64'(0));
    chk("rst2.id_pc",     64'(id_pc),     64'(0));
    chk("rst2.id_inst",   64'(id_inst),   64'(NOP));
    chk("rst2.id_exc",    64'(id_exc),    64'(0));
    chk("rst2.stall_cnt", 64'(stall_cnt), 64'(0));
    drive(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1); cycle();
    chk("rst2.lat1_valid", 64'(id_valid), 64'(1));
    chk("rst2.lat1_pc",    64'(id_pc),    64'(32'h40));
    chk("rst2.lat1_exc",   64'(id_exc),   64'(1));

    // Saturation of the 2-bit counter
    do_reset();
    drive(1'b1, 1'b1, 32'h50, 1'b0, 1'b0, 1'b0); cycle();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0); cycle();
      chk($sformatf("sat%0d", k), 64'(s_stall_cnt), 64'(sat_exp[k]));
      chk($sformatf("sat%0d.wide", k), 64'(stall_cnt), 64'(k + 1));
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 63) != 0);
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc    = $urandom;
      if_inst  = $urandom;
      if_exc   = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      id_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (3) cycle();

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
